aes_core_arbiter: RTL and testbench

AES_CORE_ARBITER -- requirements
Module: aes_core_arbiter

---
 rtl/aes_core_arbiter_if.sv | 45 ++++
 rtl/aes_core_arbiter.sv | 139 +++++++++++++
 tb/tb_aes_core_arbiter.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_core_arbiter_if.sv
// -----------------------------------------------------------------------------
// aes_core_arbiter_if
// Groups the two requester ports, the shared response bus and the shared AES
// core handshake used by aes_core_arbiter.
//   req0/req1, data0/data1, key0/key1 : requester operands (level request)
//   gnt0/gnt1                         : one-cycle accept pulses
//   resp_valid0/resp_valid1           : one-cycle response pulses per requester
//   resp_data, resp_err               : shared response bus
//   busy                              : arbiter not idle
//   core_start, core_data, core_key   : issue side towards the AES core
//   core_done, core_result            : completion side from the AES core
// Modports: slave = arbiter view, master = requester/core environment view.
// -----------------------------------------------------------------------------
interface aes_core_arbiter_if;
  logic         req0;
  logic         req1;
  logic [127:0] data0;
  logic [127:0] data1;
  logic [127:0] key0;
  logic [127:0] key1;
  logic         gnt0;
  logic         gnt1;
  logic         resp_valid0;
  logic         resp_valid1;
  logic [127:0] resp_data;
  logic         resp_err;
  logic         busy;
  logic         core_start;
  logic [127:0] core_data;
  logic [127:0] core_key;
  logic         core_done;
  logic [127:0] core_result;

  modport slave (
    input  req0, req1, data0, data1, key0, key1, core_done, core_result,
    output gnt0, gnt1, resp_valid0, resp_valid1, resp_data, resp_err, busy,
           core_start, core_data, core_key
  );

  modport master (
    output req0, req1, data0, data1, key0, key1, core_done, core_result,
    input  gnt0, gnt1, resp_valid0, resp_valid1, resp_data, resp_err, busy,
           core_start, core_data, core_key
  );
endinterface

// File: rtl/aes_core_arbiter.sv
// -----------------------------------------------------------------------------
// aes_core_arbiter
// Shares one AES core between two requesters with round-robin arbitration and
// a single operation in flight (IDLE -> ISSUE -> WAIT -> RESP -> IDLE).
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high reset
//   bus   : aes_core_arbiter_if.slave (requesters, response bus, core handshake)
// Parameter:
//   TIMEOUT_CYCLES : WAIT cycles before abort (only with AES_ARB_TIMEOUT_EN)
// Build option:
//   AES_ARB_TIMEOUT_EN defined -> WAIT aborts after TIMEOUT_CYCLES cycles without
//   core_done and answers the owner with resp_err = 1, resp_data = 0.
//   Undefined (default)        -> WAIT is held until core_done, resp_err is 0.
// -----------------------------------------------------------------------------
module aes_core_arbiter #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic               clk,
  input  logic               reset,
  aes_core_arbiter_if.slave  bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  logic [1:0] state_r;
  logic       owner_r;   // requester owning the operation in flight
  logic       last_r;    // requester granted most recently (completed op)
  logic       winner_s;
  logic       any_req_s;

`ifdef AES_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_r;
`endif

  // Round-robin pick: a lone request wins, a tie goes to the one not granted last.
  always_comb begin
    winner_s  = 1'b0;
    any_req_s = bus.req0 | bus.req1;
    if (bus.req0 && bus.req1) begin
      winner_s = ~last_r;
    end else if (bus.req1) begin
      winner_s = 1'b1;
    end else begin
      winner_s = 1'b0;
    end
  end

  // Arbiter FSM with registered grant, start, response and operand outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r         <= ST_IDLE;
      owner_r         <= 1'b0;
      last_r          <= 1'b1;
      bus.gnt0        <= 1'b0;
      bus.gnt1        <= 1'b0;
      bus.resp_valid0 <= 1'b0;
      bus.resp_valid1 <= 1'b0;
      bus.resp_data   <= 128'd0;
      bus.resp_err    <= 1'b0;
      bus.busy        <= 1'b0;
      bus.core_start  <= 1'b0;
      bus.core_data   <= 128'd0;
      bus.core_key    <= 128'd0;
`ifdef AES_ARB_TIMEOUT_EN
      cnt_r           <= '0;
`endif
    end else begin
      // Pulse outputs default low; each is raised for exactly one state.
      bus.gnt0        <= 1'b0;
      bus.gnt1        <= 1'b0;
      bus.core_start  <= 1'b0;
      bus.resp_valid0 <= 1'b0;
      bus.resp_valid1 <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (any_req_s) begin
            state_r        <= ST_ISSUE;
            owner_r        <= winner_s;
            bus.core_data  <= winner_s ? bus.data1 : bus.data0;
            bus.core_key   <= winner_s ? bus.key1  : bus.key0;
            bus.gnt0       <= ~winner_s;
            bus.gnt1       <= winner_s;
            bus.core_start <= 1'b1;
            bus.busy       <= 1'b1;
          end else begin
            state_r  <= ST_IDLE;
            bus.busy <= 1'b0;
          end
        end
        ST_ISSUE: begin
          state_r <= ST_WAIT;
`ifdef AES_ARB_TIMEOUT_EN
          cnt_r   <= '0;
`endif
        end
        ST_WAIT: begin
          // core_done takes priority over an expiry in the same cycle.
          if (bus.core_done) begin
            state_r         <= ST_RESP;
            bus.resp_data   <= bus.core_result;
            bus.resp_err    <= 1'b0;
            bus.resp_valid0 <= ~owner_r;
            bus.resp_valid1 <= owner_r;
`ifdef AES_ARB_TIMEOUT_EN
          end else if (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            state_r         <= ST_RESP;
            bus.resp_data   <= 128'd0;
            bus.resp_err    <= 1'b1;
            bus.resp_valid0 <= ~owner_r;
            bus.resp_valid1 <= owner_r;
          end else begin
            state_r <= ST_WAIT;
            cnt_r   <= cnt_r + CNT_W'(1);
          end
`else
          end else begin
            state_r <= ST_WAIT;
          end
`endif
        end
        ST_RESP: begin
          state_r  <= ST_IDLE;
          last_r   <= owner_r;
          bus.busy <= 1'b0;
        end
        default: begin
          state_r  <= ST_IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_core_arbiter.sv
// -----------------------------------------------------------------------------
// tb_aes_core_arbiter
// Directed bench for aes_core_arbiter. Expected responses are queued when the
// bench returns core_done (or arms a timeout) and are popped by a monitor that
// watches resp_valid0/resp_valid1 on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_aes_core_arbiter;

  typedef struct {
    bit           id;
    logic [127:0] data;
    logic         err;
  } resp_t;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  resp_t sb[$];

  logic [127:0] last_result;

  aes_core_arbiter_if bus ();

  aes_core_arbiter #(.TIMEOUT_CYCLES(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: every response pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset) begin
      chk("gnt_exclusive", {127'd0, bus.gnt0 & bus.gnt1}, 128'd0);
      if (bus.resp_valid0 || bus.resp_valid1) begin
        if (sb.size() == 0) begin
          chk("resp_unexpected", {126'd0, bus.resp_valid1, bus.resp_valid0}, 128'd0);
        end else begin
          resp_t e;
          e = sb.pop_front();
          chk("resp_owner", {126'd0, bus.resp_valid1, bus.resp_valid0},
              e.id ? 128'd2 : 128'd1);
          chk("resp_data", bus.resp_data, e.data);
          chk("resp_err", {127'd0, bus.resp_err}, {127'd0, e.err});
        end
      end
    end
  end

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // Runs one operation from IDLE with requests already driven. The granted
  // requester drops its request on the grant; core_done comes wait_cycles after
  // core_start.
  task automatic run_op(input bit exp_id, input int wait_cycles, input logic [127:0] result);
    logic [127:0] exp_data;
    logic [127:0] exp_key;
    exp_data = exp_id ? bus.data1 : bus.data0;
    exp_key  = exp_id ? bus.key1  : bus.key0;
    tick();
    chk("op_gnt0", {127'd0, bus.gnt0}, {127'd0, ~exp_id});
    chk("op_gnt1", {127'd0, bus.gnt1}, {127'd0, exp_id});
    chk("op_core_start", {127'd0, bus.core_start}, 128'd1);
    chk("op_busy", {127'd0, bus.busy}, 128'd1);
    chk("op_core_data", bus.core_data, exp_data);
    chk("op_core_key", bus.core_key, exp_key);
    if (exp_id) bus.req1 = 1'b0;
    else        bus.req0 = 1'b0;
    tick();
    chk("op_gnt_pulse", {126'd0, bus.gnt1, bus.gnt0}, 128'd0);
    chk("op_start_pulse", {127'd0, bus.core_start}, 128'd0);
    repeat (wait_cycles - 1) tick();
    chk("op_no_early_resp", {126'd0, bus.resp_valid1, bus.resp_valid0}, 128'd0);
    bus.core_done   = 1'b1;
    bus.core_result = result;
    sb.push_back('{id: exp_id, data: result, err: 1'b0});
    tick();
    bus.core_done = 1'b0;
    chk("op_resp_latency", {126'd0, bus.resp_valid1, bus.resp_valid0},
        exp_id ? 128'd2 : 128'd1);
    tick();
    chk("op_idle_busy", {127'd0, bus.busy}, 128'd0);
    chk("op_resp_hold", bus.resp_data, result);
    last_result = result;
  endtask

  initial begin
    checks          = 0;
    failures        = 0;
    reset           = 1'b1;
    bus.req0        = 1'b0;
    bus.req1        = 1'b0;
    bus.data0       = 128'd0;
    bus.data1       = 128'd0;
    bus.key0        = 128'd0;
    bus.key1        = 128'd0;
    bus.core_done   = 1'b0;
    bus.core_result = 128'd0;
    last_result     = 128'd0;
    tick();
    tick();

    // Reset state
    chk("rst_outputs", {121'd0, bus.gnt0, bus.gnt1, bus.resp_valid0, bus.resp_valid1,
                        bus.resp_err, bus.busy, bus.core_start}, 128'd0);
    chk("rst_resp_data", bus.resp_data, 128'd0);
    chk("rst_core_data", bus.core_data, 128'd0);
    chk("rst_core_key", bus.core_key, 128'd0);
    reset = 1'b0;
    tick();

    // Single request from requester 0, core answers 10 cycles after start
    bus.req0  = 1'b1;
    bus.data0 = 128'h1;
    bus.key0  = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
    run_op(1'b0, 10, 128'h3ad77bb4_0d7a3660_a89ecaf3_2466ef97);

    // Simultaneous requests from reset pointer: order 0, 1, 0 then idle
    pulse_reset();
    bus.req0  = 1'b1;
    bus.req1  = 1'b1;
    bus.data0 = 128'h00000000_00000000_00000000_00000011;
    bus.key0  = 128'hffeeddcc_bbaa9988_77665544_33221100;
    bus.data1 = 128'hf0f1f2f3_f4f5f6f7_f8f9fafb_fcfdfeff;
    bus.key1  = 128'h00112233_44556677_8899aabb_ccddeeff;
    run_op(1'b0, 3, 128'hAAAA0000);
    bus.req0 = 1'b1;
    run_op(1'b1, 1, 128'hBBBB1111);
    run_op(1'b0, 5, 128'hCCCC2222);
    tick();
    tick();
    chk("rr_idle_gnt", {126'd0, bus.gnt1, bus.gnt0}, 128'd0);
    chk("rr_idle_busy", {127'd0, bus.busy}, 128'd0);

    // req1 raised while requester 0 is waiting on the core
    bus.req0 = 1'b1;
    bus.data0 = 128'h5555;
    tick();
    chk("late_gnt0", {127'd0, bus.gnt0}, 128'd1);
    bus.req0 = 1'b0;
    tick();
    bus.req1 = 1'b1;
    repeat (3) begin
      tick();
      chk("late_no_gnt1_wait", {127'd0, bus.gnt1}, 128'd0);
    end
    bus.core_done   = 1'b1;
    bus.core_result = 128'hDDDD3333;
    sb.push_back('{id: 1'b0, data: 128'hDDDD3333, err: 1'b0});
    tick();
    bus.core_done = 1'b0;
    chk("late_resp0", {127'd0, bus.resp_valid0}, 128'd1);
    chk("late_no_gnt1_resp", {127'd0, bus.gnt1}, 128'd0);
    tick();
    chk("late_no_gnt1_idle", {127'd0, bus.gnt1}, 128'd0);
    run_op(1'b1, 2, 128'hEEEE4444);

    // Stray core_done while idle changes nothing
    bus.core_done   = 1'b1;
    bus.core_result = 128'hDEADBEEF;
    tick();
    bus.core_done = 1'b0;
    chk("stray_resp_data", bus.resp_data, last_result);
    chk("stray_busy", {127'd0, bus.busy}, 128'd0);
    chk("stray_resp_valid", {126'd0, bus.resp_valid1, bus.resp_valid0}, 128'd0);
    tick();
    chk("stray_busy_after", {127'd0, bus.busy}, 128'd0);

    // Reset in the middle of WAIT discards the operation
    bus.req1 = 1'b1;
    tick();
    bus.req1 = 1'b0;
    tick();
    tick();
    chk("midwait_busy", {127'd0, bus.busy}, 128'd1);
    reset = 1'b1;
    #1;
    chk("midwait_rst_busy", {127'd0, bus.busy}, 128'd0);
    chk("midwait_rst_data", bus.resp_data, 128'd0);
    tick();
    reset = 1'b0;
    bus.core_done   = 1'b1;
    bus.core_result = 128'h12345678;
    tick();
    bus.core_done = 1'b0;
    chk("midwait_no_resp", {126'd0, bus.resp_valid1, bus.resp_valid0}, 128'd0);
    chk("midwait_idle", {127'd0, bus.busy}, 128'd0);
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    run_op(1'b0, 2, 128'h9999);
    run_op(1'b1, 2, 128'h8888);

    // Core never answers
    bus.req1 = 1'b1;
    tick();
    chk("to_gnt1", {127'd0, bus.gnt1}, 128'd1);
    bus.req1 = 1'b0;
    tick();
`ifdef AES_ARB_TIMEOUT_EN
    sb.push_back('{id: 1'b1, data: 128'd0, err: 1'b1});
    repeat (63) tick();
    chk("to_not_yet", {127'd0, bus.resp_valid1}, 128'd0);
    tick();
    chk("to_resp1", {127'd0, bus.resp_valid1}, 128'd1);
    chk("to_err", {127'd0, bus.resp_err}, 128'd1);
    chk("to_data", bus.resp_data, 128'd0);
    tick();
    chk("to_idle", {127'd0, bus.busy}, 128'd0);
`else
    repeat (100) tick();
    chk("to_busy_held", {127'd0, bus.busy}, 128'd1);
    chk("to_no_resp", {126'd0, bus.resp_valid1, bus.resp_valid0}, 128'd0);
    chk("to_err_zero", {127'd0, bus.resp_err}, 128'd0);
    pulse_reset();
`endif
    tick();

    chk("sb_drained", 128'(sb.size()), 128'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
